multi_motor_controller: RTL
===========================

// Module: multi_motor_controller
// PURPOSE
//  NUM_CH-channel successor to the single-channel motor controller.
//  - One Avalon-MM slave, with a 4-register bank per channel.
//  - Per-channel fault/brake latches and event flags.
//  - Each channel has a slew-rate limiter between the POWER target and its PWM driver stream.
//  - Each channel has a command watchdog that brakes the motor if the CPU stops writing POWER.
//  Sits between the Nios/Avalon fabric and NUM_CH pwm drivers (Avalon-ST sinks).
// PARAMETERS
//  NUM_CH       4     number of motor channels (1..8)
//  PWM_LIMIT    2985  |POWER| clamp; written values saturate to +/-PWM_LIMIT
//  SLEW_STEP    64    max change of the applied power per slew tick (>=1)
//  SLEW_PERIOD  1000  clk cycles between slew ticks (>=1)
//  WDT_CYCLES   0     watchdog timeout in clk cycles; 0 disables the watchdog
// PORTS
//  clk                    in   1          system clock
//  reset_n                in   1          asynchronous reset, active-low
//  fault                  out  NUM_CH     per-channel fault output
//  brake                  out  NUM_CH     per-channel short-brake output
//  status_driver_otw_n    in   NUM_CH     driver over-temperature warning, active-low
//  status_driver_fault_n  in   NUM_CH     driver fault, active-low
//  status_hall_fault_n    in   NUM_CH     hall sensor fault, active-low
//  pwm_source_data        out  16*NUM_CH  signed applied power; channel c in bits [16c+15:16c]
//  pwm_source_valid       out  NUM_CH     Avalon-ST valid, one per channel
//  pwm_source_ready       in   NUM_CH     Avalon-ST ready, one per channel
//  slave_address          in   AW         AW = clog2(NUM_CH)+2; [AW-1:2] = channel, [1:0] = register
//  slave_readdata         out  16         read data, registered, latency 1
//  slave_writedata        in   16         write data
//  slave_read             in   1          read strobe
//  slave_write            in   1          write strobe
//  irq                    out  1          registered OR of all cleared INTFLAG bits, all channels
// BEHAVIOUR
//  Registers per channel:
//  - 0 STATUS (RO): {12'b0, slewing, otw_n, drvfault_n, hallfault_n}; slewing = (applied != target).
//  - 1 INTFLAG (RO): {12'b0, wdt_n, otw_n, drvfault_n, hallfault_n}.
//    - Each bit is 1 at idle and is cleared on a falling edge of its source.
//    - Reading sets all 4 bits of that channel to 1; an event in the same cycle wins (bit stays 0).
//  - 2 CONTROL (R/W): write bit0 FAULT_SET, bit1 FAULT_CLR, bit2 BRAKE_SET, bit3 BRAKE_CLR.
//    - SET beats CLR.
//    - Reads return {13'b0, brake, 1'b0, fault}.
//  - 3 POWER (R/W): signed target, saturated to +/-PWM_LIMIT on write; reads return the stored target.
//  - Channel index >= NUM_CH: reads return 0, writes are ignored.
//  Reset (reset_n=0), asynchronous:
//  - fault, brake, irq, pwm_source_valid, pwm_source_data and slave_readdata are 0.
//  - target and applied are 0; all INTFLAG bits are 1.
//  - The slew prescaler is 0; the watchdog is disarmed.
//  Fault:
//  - Any status input low sets fault the next cycle (fault is level-held while any input is low).
//  - A status falling edge also clears the matching INTFLAG bit.
//  - While fault=1: target and applied are forced to 0 immediately (no slew), and POWER writes are discarded.
//  - FAULT_CLR takes effect only when all status inputs are high.
//  Slew:
//  - A global prescaler counts 0..SLEW_PERIOD-1; a tick occurs at wrap.
//  - On a tick, each channel moves applied toward target by min(SLEW_STEP, |target-applied|).
//  - No overshoot.
//  Output stage, per channel:
//  - If valid=0 and data != applied: load data <= applied and set valid=1 next cycle.
//  - Data is held stable while valid=1; valid drops on valid&ready.
//  - Intermediate values may be skipped if the sink stalls; the last applied value is always sent.
//  Watchdog (WDT_CYCLES>0):
//  - A POWER write loads the counter with WDT_CYCLES and arms it; the counter decrements each cycle.
//  - On reaching 0: target <= 0, brake <= 1, INTFLAG.wdt_n <= 0, and the watchdog disarms.
//  - Applied power then slews to 0.
//  - A POWER write in the expiry cycle wins: counter reloads, no expiry.
// TESTING
//  - Ramp: SLEW_STEP=64, SLEW_PERIOD=4, write POWER=300 -> data sequence 64,128,192,256,300, one per 4 clk, ready=1.
//  - Saturation: write -5000 -> POWER reads -2985; write 0x7FFF -> reads 2985.
//  - Fault: ch1 applied=1000, pulse status_driver_fault_n[1] low 1 clk:
//    - fault[1]=1, data=0 without slew, INTFLAG[1]=0b1101, irq=1.
//    - Reading INTFLAG -> 0b1111, irq=0 two cycles later.
//    - CONTROL write 0x2 -> fault[1]=0.
//  - Watchdog: WDT_CYCLES=100, write POWER=500, no further writes -> at cycle 100 brake=1, wdt_n=0, irq=1, applied ramps to 0.
//    - A write at cycle 99 -> no expiry.
//  - Backpressure: hold ready[2]=0 across 3 ticks -> data/valid stable; release -> latest applied value sent.
//  - Reset mid-ramp: drop reset_n at an arbitrary cycle -> all outputs 0 asynchronously.
//    - After release, no valid until a POWER write.

Source files
------------

// File: rtl/multi_motor_controller.sv
// Multi-channel motor controller: Avalon-MM register bank, per-channel fault/brake latches,
// slew-rate limited power targets, command watchdogs and Avalon-ST PWM output streams.
module multi_motor_controller #(
  parameter  int NUM_CH      = 4,
  parameter  int PWM_LIMIT   = 2985,
  parameter  int SLEW_STEP   = 64,
  parameter  int SLEW_PERIOD = 1000,
  parameter  int WDT_CYCLES  = 0,
  localparam int AW          = $clog2(NUM_CH) + 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [NUM_CH-1:0]      fault,
  output logic [NUM_CH-1:0]      brake,
  input  logic [NUM_CH-1:0]      status_driver_otw_n,
  input  logic [NUM_CH-1:0]      status_driver_fault_n,
  input  logic [NUM_CH-1:0]      status_hall_fault_n,
  output logic [16*NUM_CH-1:0]   pwm_source_data,
  output logic [NUM_CH-1:0]      pwm_source_valid,
  input  logic [NUM_CH-1:0]      pwm_source_ready,
  input  logic [AW-1:0]          slave_address,
  output logic [15:0]            slave_readdata,
  input  logic [15:0]            slave_writedata,
  input  logic                   slave_read,
  input  logic                   slave_write,
  output logic                   irq
);

  localparam int CHW = (AW > 2) ? AW - 2 : 1;
  localparam int PW  = (SLEW_PERIOD > 1) ? $clog2(SLEW_PERIOD) : 1;
  localparam int WW  = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES + 1) : 1;

  localparam logic signed [15:0] LIM_P    = 16'(PWM_LIMIT);
  localparam logic signed [15:0] LIM_N    = -LIM_P;
  localparam logic signed [15:0] STEP16   = 16'(SLEW_STEP);
  localparam logic signed [16:0] STEP17   = 17'(SLEW_STEP);
  localparam logic signed [16:0] NSTEP17  = -STEP17;
  localparam logic [PW-1:0]      PRESC_TC = PW'(SLEW_PERIOD - 1);
  localparam logic [WW-1:0]      WDT_LOAD = WW'(WDT_CYCLES);
  localparam logic [CHW:0]       NCH      = (CHW + 1)'(NUM_CH);

  function automatic logic signed [15:0] sat(input logic signed [15:0] v);
    if (v > LIM_P) return LIM_P;
    if (v < LIM_N) return LIM_N;
    return v;
  endfunction

  // Step a toward t by at most SLEW_STEP; lands exactly on t when close enough.
  function automatic logic signed [15:0] slew(input logic signed [15:0] a,
                                               input logic signed [15:0] t);
    logic signed [16:0] diff;
    diff = $signed({t[15], t}) - $signed({a[15], a});
    if (diff > STEP17)  return a + STEP16;
    if (diff < NSTEP17) return a - STEP16;
    return t;
  endfunction

  logic [CHW-1:0] sel_ch;
  logic [1:0]     sel_reg;
  logic           sel_ok;

  if (AW > 2) begin : g_sel_multi
    assign sel_ch = slave_address[AW-1:2];
  end else begin : g_sel_single
    assign sel_ch = '0;
  end

  assign sel_reg = slave_address[1:0];
  assign sel_ok  = ({1'b0, sel_ch} < NCH);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick    = (presc_q == PRESC_TC);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  logic [16*NUM_CH-1:0] tgt_v;
  logic [4*NUM_CH-1:0]  flag_v;
  logic [NUM_CH-1:0]    slew_v;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [15:0] tgt_q, tgt_d, app_q, app_d, dat_q, dat_d;
    logic               vld_q, vld_d, flt_q, flt_d, brk_q, brk_d, arm_q, arm_d;
    logic [3:0]         flag_q, flag_d;
    logic [2:0]         st, prev_q, fall;
    logic [WW-1:0]      cnt_q, cnt_d;
    logic               hit, wr_ctl, wr_pwr, rd_flag, pwr_ok, expire;

    assign st      = {status_driver_otw_n[c], status_driver_fault_n[c], status_hall_fault_n[c]};
    assign fall    = prev_q & ~st;
    assign hit     = sel_ok && (sel_ch == CHW'(c));
    assign wr_ctl  = slave_write && hit && (sel_reg == 2'd2);
    assign wr_pwr  = slave_write && hit && (sel_reg == 2'd3);
    assign rd_flag = slave_read  && hit && (sel_reg == 2'd1);
    assign pwr_ok  = wr_pwr && !flt_q;
    // A fresh POWER write in the terminal cycle reloads instead of expiring.
    assign expire  = (WDT_CYCLES > 0) && arm_q && (cnt_q == WW'(1)) && !pwr_ok;

    always_comb begin
      flt_d = flt_q;
      if (wr_ctl && slave_writedata[1] && (&st)) flt_d = 1'b0;
      if (wr_ctl && slave_writedata[0])          flt_d = 1'b1;
      if (!(&st))                                flt_d = 1'b1;

      brk_d = brk_q;
      if (wr_ctl && slave_writedata[3]) brk_d = 1'b0;
      if (wr_ctl && slave_writedata[2]) brk_d = 1'b1;
      if (expire)                       brk_d = 1'b1;

      cnt_d = cnt_q;
      arm_d = arm_q;
      if (pwr_ok) begin
        cnt_d = WDT_LOAD;
        arm_d = (WDT_CYCLES > 0);
      end else if (arm_q) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WW'(1)) arm_d = 1'b0;
      end

      tgt_d = tgt_q;
      if (pwr_ok)          tgt_d = sat($signed(slave_writedata));
      if (expire || flt_d) tgt_d = '0;

      app_d = tick ? slew(app_q, tgt_q) : app_q;
      if (flt_d) app_d = '0;

      flag_d = (rd_flag ? 4'hF : flag_q) & ~{expire, fall};

      vld_d = vld_q;
      dat_d = dat_q;
      if (vld_q) begin
        if (pwm_source_ready[c]) vld_d = 1'b0;
      end else if (dat_q != app_q) begin
        dat_d = app_q;
        vld_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        tgt_q  <= '0;
        app_q  <= '0;
        dat_q  <= '0;
        vld_q  <= 1'b0;
        flt_q  <= 1'b0;
        brk_q  <= 1'b0;
        arm_q  <= 1'b0;
        cnt_q  <= '0;
        flag_q <= 4'hF;
        prev_q <= 3'b111;
      end else begin
        tgt_q  <= tgt_d;
        app_q  <= app_d;
        dat_q  <= dat_d;
        vld_q  <= vld_d;
        flt_q  <= flt_d;
        brk_q  <= brk_d;
        arm_q  <= arm_d;
        cnt_q  <= cnt_d;
        flag_q <= flag_d;
        prev_q <= st;
      end
    end

    assign fault[c]                   = flt_q;
    assign brake[c]                   = brk_q;
    assign pwm_source_valid[c]        = vld_q;
    assign pwm_source_data[16*c +: 16] = dat_q;
    assign tgt_v[16*c +: 16]          = tgt_q;
    assign flag_v[4*c +: 4]           = flag_q;
    assign slew_v[c]                  = (app_q != tgt_q);
  end

  logic [15:0] rdata_q, rdata_d, rd_val;
  logic        irq_q, irq_d;

  always_comb begin
    rd_val = '0;
    if (sel_ok) begin
      case (sel_reg)
        2'd0: rd_val = {12'b0, slew_v[sel_ch], status_driver_otw_n[sel_ch],
                        status_driver_fault_n[sel_ch], status_hall_fault_n[sel_ch]};
        2'd1: rd_val = {12'b0, flag_v[4*sel_ch +: 4]};
        2'd2: rd_val = {13'b0, brake[sel_ch], 1'b0, fault[sel_ch]};
        default: rd_val = tgt_v[16*sel_ch +: 16];
      endcase
    end
    rdata_d = slave_read ? rd_val : rdata_q;
    irq_d   = |(~flag_v);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign slave_readdata = rdata_q;
  assign irq            = irq_q;

endmodule
